cu_operand_stage: RTL and testbench

//  Operand-fetch / writeback stage wrapped around the CU compute unit. Accepts decoded

---
 rtl/cu_operand_stage.sv | 170 +++++++++++++++++
 tb/tb_cu_operand_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_operand_stage.sv
// Operand-fetch / writeback stage around the CU compute unit.
// Instructions {op, rd, rs1, rs2} read their operands from a local register
// file, with the in-flight execute result forwarded, into an execute register
// that drives the CU. The CU result and flags are retired one cycle later.
// Dependent instructions can issue every cycle without stalling.
// Operation codes pass through unmodified. Code 0 is the value cu_op takes
// out of reset.
module cu_operand_stage #(
    parameter int NREGS    = 8,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1,
    parameter int OPW      = 3,
    parameter int FW       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [OPW-1:0]  instr_op,
    input  logic [AW-1:0]   instr_rd,
    input  logic [AW-1:0]   instr_rs1,
    input  logic [AW-1:0]   instr_rs2,
    input  logic            hold,
    output logic [15:0]     cu_op1,
    output logic [15:0]     cu_op2,
    output logic [OPW-1:0]  cu_op,
    input  logic [15:0]     cu_result,
    input  logic [FW-1:0]   cu_fls,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_rd,
    output logic [15:0]     wb_data,
    output logic [FW-1:0]   flags_q,
    input  logic [AW-1:0]   dbg_addr,
    output logic [15:0]     dbg_data
);

    // Architectural register file. It has three combinational read ports
    // (rs1, rs2, dbg), so it is built from flops.
    logic [15:0]    regs_q [NREGS];

    // Execute register
    logic           ex_valid_q, ex_valid_d;
    logic [AW-1:0]  ex_rd_q,    ex_rd_d;
    logic [OPW-1:0] ex_op_q,    ex_op_d;
    logic [15:0]    ex_a_q,     ex_a_d;
    logic [15:0]    ex_b_q,     ex_b_d;

    // Writeback / flags registers
    logic           wb_valid_q, wb_valid_d;
    logic [AW-1:0]  wb_rd_q,    wb_rd_d;
    logic [15:0]    wb_data_q,  wb_data_d;
    logic [FW-1:0]  flags_q_q,  flags_q_d;

    logic fire;
    logic retire;
    logic ex_drop;      // the in-flight write targets the hard-wired zero register
    logic fwd_ok;       // the in-flight result may be forwarded
    logic [15:0] src_a;
    logic [15:0] src_b;

    assign instr_ready = !hold;
    assign fire        = instr_valid && !hold;
    assign retire      = ex_valid_q && !hold;
    assign ex_drop     = (ZERO_REG != 0) && (ex_rd_q == '0);
    assign fwd_ok      = ex_valid_q && !ex_drop;

    // Operand A select: hard zero, forwarded in-flight result, or register file
    always_comb begin
        src_a = regs_q[instr_rs1];
        if ((ZERO_REG != 0) && (instr_rs1 == '0)) begin
            src_a = 16'd0;
        end else if (fwd_ok && (ex_rd_q == instr_rs1)) begin
            src_a = cu_result;
        end
    end

    // Operand B select: same rules as operand A
    always_comb begin
        src_b = regs_q[instr_rs2];
        if ((ZERO_REG != 0) && (instr_rs2 == '0)) begin
            src_b = 16'd0;
        end else if (fwd_ok && (ex_rd_q == instr_rs2)) begin
            src_b = cu_result;
        end
    end

    // Execute-register next state. It loads on issue, empties after a lone
    // retire, and stays frozen while hold is high.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        if (fire) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = instr_rd;
            ex_op_d    = instr_op;
            ex_a_d     = src_a;
            ex_b_d     = src_b;
        end else if (retire) begin
            ex_valid_d = 1'b0;
        end
    end

    // Writeback next state. The pulse lasts one cycle per retire, and flags
    // update even for dropped writes to r0.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        flags_q_d  = flags_q_q;
        if (retire) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd_q;
            wb_data_d  = ex_drop ? 16'd0 : cu_result;
            flags_q_d  = cu_fls;
        end
    end

    // Execute and writeback state registers. Reset discards any in-flight
    // instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_op_q    <= '0;
            ex_a_q     <= 16'd0;
            ex_b_q     <= 16'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= 16'd0;
            flags_q_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            flags_q_q  <= flags_q_d;
        end
    end

    // Register-file write: one retire port, and r0 stays zero when hard-wired
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= 16'd0;
                end else if (retire && !ex_drop && (ex_rd_q == AW'(gi))) begin
                    regs_q[gi] <= cu_result;
                end
            end
        end
    endgenerate

    assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? 16'd0 : regs_q[dbg_addr];

    assign cu_op1   = ex_a_q;
    assign cu_op2   = ex_b_q;
    assign cu_op    = ex_op_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign flags_q  = flags_q_q;

endmodule

// File: tb/tb_cu_operand_stage.sv
// Self-checking bench for cu_operand_stage. A behavioural CU drives
// cu_result/cu_fls. A program-order register model pushes the expected
// writeback on each accepted instruction, and a negedge monitor pops and
// compares it on each wb_valid.
module tb_cu_operand_stage;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs1, instr_rs2;
    logic        hold;
    logic [15:0] cu_op1, cu_op2;
    logic [2:0]  cu_op;
    logic [15:0] cu_result;
    logic [3:0]  cu_fls;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [3:0]  flags_q;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    cu_operand_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .hold        (hold),
        .cu_op1      (cu_op1),
        .cu_op2      (cu_op2),
        .cu_op       (cu_op),
        .cu_result   (cu_result),
        .cu_fls      (cu_fls),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flags_q     (flags_q),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural CU: returns {flags, result}.
    // flags = {odd parity, carry/overflow, negative, zero}
    function automatic logic [19:0] cu_func(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [31:0] w;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        case (op)
            OP_ADD:  begin w = {16'd0, a} + {16'd0, b}; c = w[16]; end
            OP_SUB:  begin w = {16'd0, a} - {16'd0, b}; c = w[16]; end
            OP_MUL:  begin w = {16'd0, a} * {16'd0, b}; c = |w[31:16]; end
            OP_INC:  begin w = {16'd0, a} + 32'd1;      c = w[16]; end
            default: w = 32'd0;
        endcase
        r = w[15:0];
        return {^r, c, r[15], (r == 16'd0), r};
    endfunction

    assign {cu_fls, cu_result} = cu_func(cu_op, cu_op1, cu_op2);

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
        logic [3:0]  fl;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mreg [8];

    // Scoreboard. Compare retirements first, then record newly accepted
    // instructions.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] a, b;
        logic [19:0] fr;
        if (rst) begin
            sb_q.delete();
            for (int i = 0; i < 8; i++) mreg[i] = 16'd0;
        end else begin
            if (wb_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: wb_valid=1 rd=%0d data=%0d, required no retire", wb_rd, wb_data);
                end else begin
                    e = sb_q.pop_front();
                    $display("retire rd=%0d data=%0d flags=%b", wb_rd, wb_data, flags_q);
                    if ({wb_rd, wb_data, flags_q} !== {e.rd, e.data, e.fl}) begin
                        errors++;
                        $display("FAIL wb_retire: got rd=%0d data=%0d flags=%b, required rd=%0d data=%0d flags=%b",
                                 wb_rd, wb_data, flags_q, e.rd, e.data, e.fl);
                    end
                end
            end
            if (instr_valid && instr_ready) begin
                a  = (instr_rs1 == 3'd0) ? 16'd0 : mreg[instr_rs1];
                b  = (instr_rs2 == 3'd0) ? 16'd0 : mreg[instr_rs2];
                fr = cu_func(instr_op, a, b);
                if (instr_rd != 3'd0) mreg[instr_rd] = fr[15:0];
                e.rd   = instr_rd;
                e.data = (instr_rd == 3'd0) ? 16'd0 : fr[15:0];
                e.fl   = fr[19:16];
                sb_q.push_back(e);
                $display("issue op=%0d rd=%0d rs1=%0d rs2=%0d exp=%0d", instr_op, instr_rd, instr_rs1, instr_rs2, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        tick();
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hold = 1'b0;
        instr_valid = 1'b1;
        instr_op = OP_MUL; instr_rd = 3'd3; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", instr_ready);
        end
        hold = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_hold: got %b required 0", instr_ready);
        end
        hold = 1'b0;
        tick();
        rst = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_valid, flags_q, cu_op1, cu_op2, cu_op} !== '0) begin
            errors++;
            $display("FAIL reset_state: got wb_valid=%b flags=%b op1=%0d op2=%0d op=%0d required all 0",
                     wb_valid, flags_q, cu_op1, cu_op2, cu_op);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checks++;
            if (dbg_data !== 16'd0) begin
                errors++; $display("FAIL reset_dbg r%0d: got %0d required 0", i, dbg_data);
            end
        end
        $display("reset checked");
        tick();
    endtask

    task automatic test_preload_mul();
        for (int i = 0; i < 7; i++) drive(OP_INC, 3'd1, 3'd1, 3'd0);
        drive(OP_ADD, 3'd2, 3'd1, 3'd0);
        drive(OP_INC, 3'd2, 3'd2, 3'd0);
        drive(OP_INC, 3'd2, 3'd2, 3'd0);
        idle(3);
        @(negedge clk);
        dbg_addr = 3'd1; #1;
        checks++;
        if (dbg_data !== 16'd7) begin errors++; $display("FAIL preload_r1: got %0d required 7", dbg_data); end
        dbg_addr = 3'd2; #1;
        checks++;
        if (dbg_data !== 16'd9) begin errors++; $display("FAIL preload_r2: got %0d required 9", dbg_data); end
        tick();
        drive(OP_MUL, 3'd3, 3'd1, 3'd2);
        instr_valid = 1'b0;
        dbg_addr = 3'd3;
        @(negedge clk);
        checks++;
        if ({cu_op1, cu_op2, wb_valid} !== {16'd7, 16'd9, 1'b0}) begin
            errors++; $display("FAIL mul_exec: got op1=%0d op2=%0d wb_valid=%b required 7 9 0", cu_op1, cu_op2, wb_valid);
        end
        checks++;
        if (dbg_data !== 16'd0) begin errors++; $display("FAIL mul_dbg_old: got %0d required 0", dbg_data); end
        tick();
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_rd, wb_data, dbg_data} !== {1'b1, 3'd3, 16'd63, 16'd63}) begin
            errors++;
            $display("FAIL mul_wb: got valid=%b rd=%0d data=%0d dbg=%0d required 1 3 63 63", wb_valid, wb_rd, wb_data, dbg_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(OP_MUL, 3'd4, 3'd3, 3'd1);
        drive(OP_ADD, 3'd5, 3'd4, 3'd4);
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({cu_op1, cu_op2, cu_op} !== {16'd441, 16'd441, OP_ADD}) begin
            errors++; $display("FAIL b2b_fwd: got op1=%0d op2=%0d op=%0d required 441 441 0", cu_op1, cu_op2, cu_op);
        end
        checks++;
        if ({wb_valid, wb_data} !== {1'b1, 16'd441}) begin
            errors++; $display("FAIL b2b_wb1: got valid=%b data=%0d required 1 441", wb_valid, wb_data);
        end
        tick();
        @(negedge clk);
        dbg_addr = 3'd5; #1;
        checks++;
        if ({wb_valid, wb_data, dbg_data} !== {1'b1, 16'd882, 16'd882}) begin
            errors++; $display("FAIL b2b_wb2: got valid=%b data=%0d dbg=%0d required 1 882 882", wb_valid, wb_data, dbg_data);
        end
        idle(2);
    endtask

    task automatic test_hold();
        drive(OP_MUL, 3'd6, 3'd1, 3'd2);
        hold = 1'b1;
        instr_valid = 1'b1;
        instr_op = OP_INC; instr_rd = 3'd7; instr_rs1 = 3'd7; instr_rs2 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_ready, cu_op1, cu_op2, cu_op, wb_valid} !== {1'b0, 16'd7, 16'd9, OP_MUL, 1'b0}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got ready=%b op1=%0d op2=%0d op=%0d wb_valid=%b required 0 7 9 2 0",
                         i, instr_ready, cu_op1, cu_op2, cu_op, wb_valid);
            end
            tick();
        end
        hold = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({cu_op1, wb_valid} !== {16'd7, 1'b0}) begin
            errors++; $display("FAIL hold_release: got op1=%0d wb_valid=%b required 7 0", cu_op1, wb_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 3'd6, 16'd63}) begin
            errors++; $display("FAIL hold_wb: got valid=%b rd=%0d data=%0d required 1 6 63", wb_valid, wb_rd, wb_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL hold_pulse: got wb_valid=%b required 0", wb_valid); end
        dbg_addr = 3'd7; #1;
        checks++;
        if (dbg_data !== 16'd0) begin errors++; $display("FAIL hold_noissue_r7: got %0d required 0", dbg_data); end
        tick();
    endtask

    task automatic test_zero_reg();
        drive(OP_ADD, 3'd0, 3'd1, 3'd2);
        drive(OP_ADD, 3'd7, 3'd0, 3'd1);
        instr_valid = 1'b0;
        @(negedge clk);
        dbg_addr = 3'd0; #1;
        checks++;
        if ({cu_op1, cu_op2} !== {16'd0, 16'd7}) begin
            errors++; $display("FAIL zero_nofwd: got op1=%0d op2=%0d required 0 7", cu_op1, cu_op2);
        end
        checks++;
        if ({wb_valid, wb_rd, wb_data, flags_q, dbg_data} !== {1'b1, 3'd0, 16'd0, 4'b1000, 16'd0}) begin
            errors++;
            $display("FAIL zero_wb: got valid=%b rd=%0d data=%0d flags=%b dbg=%0d required 1 0 0 1000 0",
                     wb_valid, wb_rd, wb_data, flags_q, dbg_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wb_rd, wb_data} !== {3'd7, 16'd7}) begin
            errors++; $display("FAIL zero_next: got rd=%0d data=%0d required 7 7", wb_rd, wb_data);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        drive(OP_MUL, 3'd4, 3'd1, 3'd1);
        rst = 1'b1;
        instr_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        dbg_addr = 3'd4; #1;
        checks++;
        if ({wb_valid, dbg_data, cu_op1} !== {1'b0, 16'd0, 16'd0}) begin
            errors++; $display("FAIL rstmid_a: got wb_valid=%b r4=%0d op1=%0d required 0 0 0", wb_valid, dbg_data, cu_op1);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wb_valid, dbg_data} !== {1'b0, 16'd0}) begin
            errors++; $display("FAIL rstmid_b: got wb_valid=%b r4=%0d required 0 0", wb_valid, dbg_data);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; instr_valid = 1'b0;
        instr_op = 3'd0; instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0;
        dbg_addr = 3'd0;
        test_reset();
        test_preload_mul();
        test_back_to_back();
        test_hold();
        test_zero_reg();
        test_reset_mid();
        idle(3);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d pending retirements required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
